// File: rtl/csel_add_pkg.sv
// Shared constants, types and helpers for the pipelined carry-select adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package csel_add_pkg;

  // Width of one carry-lookahead block inside a slice.
  localparam int CLA_W = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_mode_e;

  // Legal when the word splits evenly into whole slices of whole CLA blocks.
  function automatic bit cfg_legal(input int width, input int stages, input int slice);
    return (stages >= 1) && (slice >= CLA_W) && ((slice % CLA_W) == 0) &&
           (width == stages * slice);
  endfunction

  // 4-bit carry-lookahead add; returns {carry_out, sum}.
  function automatic logic [CLA_W:0] cla4(input logic [CLA_W-1:0] x,
                                          input logic [CLA_W-1:0] y,
                                          input logic             ci);
    logic [CLA_W-1:0] g;
    logic [CLA_W-1:0] p;
    logic [CLA_W:0]   c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
           (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

endpackage

// File: rtl/carry_select_slice.sv
// Purpose: combinational SLICE-bit carry-select adder built from 4-bit CLA blocks.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing pipeline stage decides when results are captured.
// Ports: a, b (SLICE) operands; cin block-0 carry; sum (SLICE) result; cout slice carry.
module carry_select_slice
  import csel_add_pkg::*;
#(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  localparam int NBLK = SLICE / CLA_W;

  // bc[j] is the carry entering block j.
  logic [NBLK:0] bc;
  assign bc[0] = cin;

  for (genvar j = 0; j < NBLK; j++) begin : g_blk
    logic [CLA_W-1:0] xa;
    logic [CLA_W-1:0] xb;
    assign xa = a[j*CLA_W +: CLA_W];
    assign xb = b[j*CLA_W +: CLA_W];

    if (j == 0) begin : g_first
      assign {bc[1], sum[CLA_W-1:0]} = cla4(xa, xb, bc[0]);
    end else begin : g_sel
      // Both outcomes are ready before the lower carry settles; only the mux waits.
      logic [CLA_W:0] r0;
      logic [CLA_W:0] r1;
      assign r0 = cla4(xa, xb, 1'b0);
      assign r1 = cla4(xa, xb, 1'b1);
      assign {bc[j+1], sum[j*CLA_W +: CLA_W]} = bc[j] ? r1 : r0;
    end
  end

  assign cout = bc[NBLK];

endmodule

// File: rtl/csel_add_pipe.sv
// Purpose: pipelined carry-select adder/subtractor, one SLICE per stage, LSB slice first.
// Latency: STAGES cycles from input transfer to out_valid; 1 op/cycle throughput.
// Backpressure: in_ready = ~out_valid | out_ready; when low every stage register holds.
// Ports: clk, reset (async, active-high); in_valid/in_ready, a, b, sub, cin in;
//        out_valid/out_ready, sum, cout, ovf out.
// Option: define CSEL_ADD_PIPE_SAT_EN to clamp sum on signed overflow.
module csel_add_pipe
  import csel_add_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int SLICE  = WIDTH / STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  if (!cfg_legal(WIDTH, STAGES, SLICE)) begin : g_cfg_check
    $error("csel_add_pipe: WIDTH must equal STAGES*SLICE with SLICE a multiple of 4");
  end

  localparam int LAST = STAGES - 1;

  // Single global advance: the whole pipe moves or the whole pipe holds.
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  op_mode_e         mode;
  logic [WIDTH-1:0] b_eff;
  logic             c_first;
  assign mode    = op_mode_e'(sub);
  assign b_eff   = (mode == OP_SUB) ? ~b : b;
  assign c_first = (mode == OP_SUB) ? 1'b1 : cin;

  // Stage k sees the operand bits not yet consumed (RW wide), adds their low
  // slice, and hands the rest plus the finished low sum slices to stage k+1.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int RW = WIDTH - k * SLICE;

    logic [RW-1:0]          op_a;
    logic [RW-1:0]          op_b;
    logic                   c_in;
    logic                   v_in;
    logic [SLICE-1:0]       s_sum;
    logic                   s_co;
    logic [(k+1)*SLICE-1:0] s_nxt;

    if (k == 0) begin : g_in
      assign op_a  = a;
      assign op_b  = b_eff;
      assign c_in  = c_first;
      assign v_in  = in_valid;
      assign s_nxt = s_sum;
    end else begin : g_mid
      assign op_a  = g_stg[k-1].g_reg.a_q;
      assign op_b  = g_stg[k-1].g_reg.b_q;
      assign c_in  = g_stg[k-1].g_reg.c_q;
      assign v_in  = g_stg[k-1].g_reg.v_q;
      assign s_nxt = {s_sum, g_stg[k-1].g_reg.s_q};
    end

    carry_select_slice #(
      .SLICE(SLICE)
    ) u_slice (
      .a   (op_a[SLICE-1:0]),
      .b   (op_b[SLICE-1:0]),
      .cin (c_in),
      .sum (s_sum),
      .cout(s_co)
    );

    if (k < LAST) begin : g_reg
      logic [RW-SLICE-1:0]    a_q;   // skew: operand slices still to be added
      logic [RW-SLICE-1:0]    b_q;
      logic [(k+1)*SLICE-1:0] s_q;   // de-skew: finished low sum slices
      logic                   c_q;
      logic                   v_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
          c_q <= 1'b0;
          v_q <= 1'b0;
        end else if (adv) begin
          a_q <= op_a[RW-1:SLICE];
          b_q <= op_b[RW-1:SLICE];
          s_q <= s_nxt;
          c_q <= s_co;
          v_q <= v_in;
        end
      end
    end
  end

  // Last stage: full-width result, overflow detect and optional clamp.
  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] sum_nxt;
  logic             a_msb;
  logic             b_msb;
  logic             ovf_nxt;

  assign raw_sum = g_stg[LAST].s_nxt;
  assign a_msb   = g_stg[LAST].op_a[SLICE-1];
  assign b_msb   = g_stg[LAST].op_b[SLICE-1];
  assign ovf_nxt = (a_msb == b_msb) & (raw_sum[WIDTH-1] != a_msb);

`ifdef CSEL_ADD_PIPE_SAT_EN
  // Overflow direction follows the operand sign: positive clamps to max, negative to min.
  assign sum_nxt = !ovf_nxt ? raw_sum :
                   a_msb    ? {1'b1, {(WIDTH-1){1'b0}}} :
                              {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign sum_nxt = raw_sum;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= g_stg[LAST].v_in;
      sum       <= sum_nxt;
      cout      <= g_stg[LAST].s_co;
      ovf       <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_csel_add_pipe.sv
// Purpose: scoreboard bench for csel_add_pipe at 32b/2 stages and 64b/4 stages.
// Latency: expects STAGES cycles per op when unstalled; order checked via queues.
// Backpressure: holds out_ready low mid-stream and checks in_ready drops.
module tb_csel_add_pipe;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        in_valid32, in_ready32, sub32, cin32, out_valid32, out_ready32, cout32, ovf32;
  logic [31:0] a32, b32, sum32;
  logic        in_valid64, in_ready64, sub64, cin64, out_valid64, out_ready64, cout64, ovf64;
  logic [63:0] a64, b64, sum64;

  csel_add_pipe #(.WIDTH(32), .STAGES(2)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .sub(sub32), .cin(cin32), .out_valid(out_valid32),
    .out_ready(out_ready32), .sum(sum32), .cout(cout32), .ovf(ovf32)
  );

  csel_add_pipe #(.WIDTH(64), .STAGES(4)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid64), .in_ready(in_ready64),
    .a(a64), .b(b64), .sub(sub64), .cin(cin64), .out_valid(out_valid64),
    .out_ready(out_ready64), .sum(sum64), .cout(cout64), .ovf(ovf64)
  );

  exp_t q32[$];
  exp_t q64[$];
  int   tests = 0;
  int   fails = 0;
  int   ov_seen32 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] s, input logic c, input logic o);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o;
    return e;
  endfunction

  // Reference: plain wide addition, independent of the slice structure.
  function automatic exp_t model(input int w, input logic [63:0] ta, input logic [63:0] tb,
                                 input logic ts, input logic tc);
    exp_t        e;
    logic [64:0] full;
    logic [63:0] mask, bp;
    logic        am, bm;
    mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    bp     = (ts ? ~tb : tb) & mask;
    full   = {1'b0, ta & mask} + {1'b0, bp} + {64'd0, (ts ? 1'b1 : tc)};
    e.sum  = full[63:0] & mask;
    e.cout = full[w];
    am     = ta[w-1];
    bm     = bp[w-1];
    e.ovf  = (am == bm) && (e.sum[w-1] != am);
`ifdef CSEL_ADD_PIPE_SAT_EN
    if (e.ovf) e.sum = am ? (64'd1 << (w-1)) : (mask >> 1);
`endif
    return e;
  endfunction

  // Monitors: compare whenever a result transfer happens at the next edge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid32) ov_seen32++;
    if (!reset && out_valid32 && out_ready32) begin
      if (q32.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out32: actual sum=%h required=no output", sum32);
      end else begin
        e = q32.pop_front();
        chk("sum32",  {32'd0, sum32}, e.sum);
        chk("cout32", {63'd0, cout32}, {63'd0, e.cout});
        chk("ovf32",  {63'd0, ovf32},  {63'd0, e.ovf});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid64 && out_ready64) begin
      if (q64.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out64: actual sum=%h required=no output", sum64);
      end else begin
        e = q64.pop_front();
        chk("sum64",  sum64, e.sum);
        chk("cout64", {63'd0, cout64}, {63'd0, e.cout});
        chk("ovf64",  {63'd0, ovf64},  {63'd0, e.ovf});
      end
    end
  end

  // Drivers: called at posedge+1, return at posedge+1 after the accepting edge.
  task automatic send32(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                        input logic tc, input exp_t e);
    int n = 0;
    a32 = ta; b32 = tb; sub32 = ts; cin32 = tc; in_valid32 = 1'b1;
    do begin @(negedge clk); n++; end while (!in_ready32 && n < 50);
    if (!in_ready32) chk("accept32_timeout", {63'd0, in_ready32}, 64'd1);
    else q32.push_back(e);
    @(posedge clk); #1;
    in_valid32 = 1'b0;
  endtask

  task automatic send64(input logic [63:0] ta, input logic [63:0] tb, input logic ts,
                        input logic tc, input exp_t e);
    int n = 0;
    a64 = ta; b64 = tb; sub64 = ts; cin64 = tc; in_valid64 = 1'b1;
    do begin @(negedge clk); n++; end while (!in_ready64 && n < 50);
    if (!in_ready64) chk("accept64_timeout", {63'd0, in_ready64}, 64'd1);
    else q64.push_back(e);
    @(posedge clk); #1;
    in_valid64 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 100) begin
      @(posedge clk); n++;
    end
    #1;
    chk("drain_q32", 64'(q32.size()), 64'd0);
    chk("drain_q64", 64'(q64.size()), 64'd0);
  endtask

  logic [63:0] sa[6];
  logic [63:0] sb[6];
  logic        ss[6];
  logic        sc[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid32 = 0; a32 = 0; b32 = 0; sub32 = 0; cin32 = 0; out_ready32 = 1;
    in_valid64 = 0; a64 = 0; b64 = 0; sub64 = 0; cin64 = 0; out_ready64 = 1;
    sa = '{64'h0123456789ABCDEF, 64'hFFFF0000FFFF0000, 64'h7FFFFFFF00000001,
           64'h8000000000000000, 64'h00000000DEADBEEF, 64'h5555AAAA5555AAAA};
    sb = '{64'h1111111111111111, 64'h0001FFFF0001FFFF, 64'h0000000100000002,
           64'h8000000000000001, 64'h00000000DEADBEEF, 64'hAAAA5555AAAA5555};
    ss = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    sc = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    #2;
    chk("rst_out_valid32", {63'd0, out_valid32}, 64'd0);
    chk("rst_sum32",       {32'd0, sum32},       64'd0);
    chk("rst_cout_ovf32",  {62'd0, cout32, ovf32}, 64'd0);
    chk("rst_in_ready32",  {63'd0, in_ready32},  64'd1);
    chk("rst_out_valid64", {63'd0, out_valid64}, 64'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Directed 32-bit vectors, hand-computed.
    send32(32'h0000FFFF, 32'h00000001, 0, 0, mk(64'h00010000, 0, 0));
    send32(32'hFFFFFFFF, 32'h00000001, 0, 0, mk(64'h00000000, 1, 0));
    send32(32'h00000005, 32'h00000007, 1, 0, mk(64'hFFFFFFFE, 0, 0));
    send32(32'h00000007, 32'h00000005, 1, 1, mk(64'h00000002, 1, 0));
    send32(32'h12345678, 32'h11111111, 0, 1, mk(64'h2345678A, 0, 0));
`ifdef CSEL_ADD_PIPE_SAT_EN
    send32(32'h7FFFFFFF, 32'h00000001, 0, 0, mk(64'h7FFFFFFF, 0, 1));
    send32(32'h80000000, 32'hFFFFFFFF, 0, 0, mk(64'h80000000, 1, 1));
    send32(32'h80000000, 32'h00000001, 1, 0, mk(64'h80000000, 1, 1));
`else
    send32(32'h7FFFFFFF, 32'h00000001, 0, 0, mk(64'h80000000, 0, 1));
    send32(32'h80000000, 32'hFFFFFFFF, 0, 0, mk(64'h7FFFFFFF, 1, 1));
    send32(32'h80000000, 32'h00000001, 1, 0, mk(64'h7FFFFFFF, 1, 1));
`endif
    drain();

    // Back-pressure, 32-bit: stall three cycles once the pipe is full.
    fork
      for (int i = 0; i < 6; i++)
        send32(sa[i][31:0], sb[i][31:0], ss[i], sc[i],
               model(32, sa[i], sb[i], ss[i], sc[i]));
      begin
        repeat (3) @(posedge clk);
        #1 out_ready32 = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_in_ready32", {63'd0, in_ready32}, 64'd0);
        end
        @(posedge clk); #1 out_ready32 = 1'b1;
      end
    join
    drain();

    // Reset with two ops in flight.
    send32(32'h11111111, 32'h22222222, 0, 0, mk(64'h33333333, 0, 0));
    send32(32'h01010101, 32'h01010101, 0, 0, mk(64'h02020202, 0, 0));
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_out_valid32", {63'd0, out_valid32}, 64'd0);
    chk("mid_rst_sum32",       {32'd0, sum32},       64'd0);
    chk("mid_rst_cout_ovf32",  {62'd0, cout32, ovf32}, 64'd0);
    q32.delete();
    ov_seen32 = 0;
    @(negedge clk); reset = 1'b0;
    #1;
    chk("post_rst_in_ready32", {63'd0, in_ready32}, 64'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("no_stale_after_rst", 64'(ov_seen32), 64'd0);
    send32(32'h00000010, 32'h00000020, 0, 0, mk(64'h00000030, 0, 0));
    drain();

    // Directed 64-bit / 4-stage vectors.
    send64(64'h000000000000FFFF, 64'd1, 0, 0, mk(64'h0000000000010000, 0, 0));
    send64(64'h0000FFFFFFFFFFFF, 64'd1, 0, 0, mk(64'h0001000000000000, 0, 0));
    send64(64'hFFFFFFFFFFFFFFFF, 64'd1, 0, 0, mk(64'h0000000000000000, 1, 0));
    send64(64'd5, 64'd7, 1, 0, mk(64'hFFFFFFFFFFFFFFFE, 0, 0));
`ifdef CSEL_ADD_PIPE_SAT_EN
    send64(64'h7FFFFFFFFFFFFFFF, 64'd1, 0, 0, mk(64'h7FFFFFFFFFFFFFFF, 0, 1));
`else
    send64(64'h7FFFFFFFFFFFFFFF, 64'd1, 0, 0, mk(64'h8000000000000000, 0, 1));
`endif
    drain();

    // Back-pressure, 64-bit: first result appears 4 edges after the first accept.
    fork
      for (int i = 0; i < 6; i++)
        send64(sa[i], sb[i], ss[i], sc[i], model(64, sa[i], sb[i], ss[i], sc[i]));
      begin
        repeat (5) @(posedge clk);
        #1 out_ready64 = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_in_ready64", {63'd0, in_ready64}, 64'd0);
        end
        @(posedge clk); #1 out_ready64 = 1'b1;
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
